// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode, EX/MEM + MEM/WB operand
// forwarding and ALUSrc immediate select, feeding the ALU in the EX stage.
module id_ex_stage #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               stall_i,
  input  logic               flush_i,
  input  logic               RegWrite_i,
  input  logic               MemtoReg_i,
  input  logic               MemRead_i,
  input  logic               MemWrite_i,
  input  logic               ALUSrc_i,
  input  logic [1:0]         ALUOp_i,
  input  logic [9:0]         funct_i,
  input  logic [XLEN-1:0]    RS1data_i,
  input  logic [XLEN-1:0]    RS2data_i,
  input  logic [XLEN-1:0]    imm_i,
  input  logic [RADDR_W-1:0] RS1addr_i,
  input  logic [RADDR_W-1:0] RS2addr_i,
  input  logic [RADDR_W-1:0] RDaddr_i,
  input  logic               EXMEM_RegWrite_i,
  input  logic [RADDR_W-1:0] EXMEM_RDaddr_i,
  input  logic [XLEN-1:0]    EXMEM_ALUres_i,
  input  logic               MEMWB_RegWrite_i,
  input  logic [RADDR_W-1:0] MEMWB_RDaddr_i,
  input  logic [XLEN-1:0]    MEMWB_WBdata_i,
  output logic [XLEN-1:0]    data1_o,
  output logic [XLEN-1:0]    data2_o,
  output logic [2:0]         ALUCtrl_o,
  output logic [XLEN-1:0]    storedata_o,
  output logic               RegWrite_o,
  output logic               MemtoReg_o,
  output logic               MemRead_o,
  output logic               MemWrite_o,
  output logic [RADDR_W-1:0] RDaddr_o,
  output logic               valid_o
);

  // ALU operation encodings seen by the downstream ALU.
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_XOR = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_ADD = 3'b011;
  localparam logic [2:0] ALU_SUB = 3'b100;
  localparam logic [2:0] ALU_MUL = 3'b101;
  localparam logic [2:0] ALU_ADDI = 3'b110;
  localparam logic [2:0] ALU_SRAI = 3'b111;

  localparam logic [1:0] OP_ITYPE = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_RTYPE = 2'b10;

  // Operand source chosen by the forwarding unit, kept visible for checkers.
  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_e;

  logic [2:0]         alu_ctrl_d;
  logic [2:0]         alu_ctrl_q;
  logic               reg_write_q;
  logic               mem_to_reg_q;
  logic               mem_read_q;
  logic               mem_write_q;
  logic               alu_src_q;
  logic               valid_q;
  logic [XLEN-1:0]    rs1_data_q;
  logic [XLEN-1:0]    rs2_data_q;
  logic [XLEN-1:0]    imm_q;
  logic [RADDR_W-1:0] rs1_addr_q;
  logic [RADDR_W-1:0] rs2_addr_q;
  logic [RADDR_W-1:0] rd_addr_q;

  fwd_sel_e           fwd_a_sel;
  fwd_sel_e           fwd_b_sel;
  logic [XLEN-1:0]    fwd_a;
  logic [XLEN-1:0]    fwd_b;

  // ALU control decode from the ID-stage fields; registered with the stage.
  always_comb begin
    alu_ctrl_d = ALU_ADD;
    unique case (ALUOp_i)
      OP_RTYPE: begin
        unique case (funct_i)
          10'b0000000_111: alu_ctrl_d = ALU_AND;
          10'b0000000_100: alu_ctrl_d = ALU_XOR;
          10'b0000000_001: alu_ctrl_d = ALU_SLL;
          10'b0000000_000: alu_ctrl_d = ALU_ADD;
          10'b0100000_000: alu_ctrl_d = ALU_SUB;
          10'b0000001_000: alu_ctrl_d = ALU_MUL;
          default:         alu_ctrl_d = ALU_ADD;
        endcase
      end
      OP_ITYPE: begin
        unique case (funct_i[2:0])
          3'b000:  alu_ctrl_d = ALU_ADDI;
          3'b101:  alu_ctrl_d = ALU_SRAI;
          default: alu_ctrl_d = ALU_ADD;
        endcase
      end
      OP_MEM:  alu_ctrl_d = ALU_ADDI;
      default: alu_ctrl_d = ALU_ADD;
    endcase
  end

  // Capture priority: flush > stall > load. A flushed slot also zeroes the
  // source addresses so a bubble can never select a forwarded value.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      alu_ctrl_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      valid_q      <= 1'b0;
      rs1_data_q   <= '0;
      rs2_data_q   <= '0;
      imm_q        <= '0;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
    end else if (flush_i) begin
      alu_ctrl_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_src_q    <= 1'b0;
      valid_q      <= 1'b0;
      rs1_data_q   <= RS1data_i;
      rs2_data_q   <= RS2data_i;
      imm_q        <= imm_i;
      rs1_addr_q   <= '0;
      rs2_addr_q   <= '0;
      rd_addr_q    <= '0;
    end else if (!stall_i) begin
      alu_ctrl_q   <= alu_ctrl_d;
      reg_write_q  <= RegWrite_i;
      mem_to_reg_q <= MemtoReg_i;
      mem_read_q   <= MemRead_i;
      mem_write_q  <= MemWrite_i;
      alu_src_q    <= ALUSrc_i;
      valid_q      <= 1'b1;
      rs1_data_q   <= RS1data_i;
      rs2_data_q   <= RS2data_i;
      imm_q        <= imm_i;
      rs1_addr_q   <= RS1addr_i;
      rs2_addr_q   <= RS2addr_i;
      rd_addr_q    <= RDaddr_i;
    end
  end

  // Forwarding: the younger EX/MEM result wins over MEM/WB; x0 never forwards.
  always_comb begin
    fwd_a_sel = FWD_REG;
    fwd_b_sel = FWD_REG;
    if (EXMEM_RegWrite_i && (EXMEM_RDaddr_i != '0) && (EXMEM_RDaddr_i == rs1_addr_q))
      fwd_a_sel = FWD_EXMEM;
    else if (MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0) && (MEMWB_RDaddr_i == rs1_addr_q))
      fwd_a_sel = FWD_MEMWB;
    if (EXMEM_RegWrite_i && (EXMEM_RDaddr_i != '0) && (EXMEM_RDaddr_i == rs2_addr_q))
      fwd_b_sel = FWD_EXMEM;
    else if (MEMWB_RegWrite_i && (MEMWB_RDaddr_i != '0) && (MEMWB_RDaddr_i == rs2_addr_q))
      fwd_b_sel = FWD_MEMWB;
  end

  always_comb begin
    fwd_a = rs1_data_q;
    fwd_b = rs2_data_q;
    unique case (fwd_a_sel)
      FWD_EXMEM: fwd_a = EXMEM_ALUres_i;
      FWD_MEMWB: fwd_a = MEMWB_WBdata_i;
      default:   fwd_a = rs1_data_q;
    endcase
    unique case (fwd_b_sel)
      FWD_EXMEM: fwd_b = EXMEM_ALUres_i;
      FWD_MEMWB: fwd_b = MEMWB_WBdata_i;
      default:   fwd_b = rs2_data_q;
    endcase
  end

  assign data1_o     = fwd_a;
  assign data2_o     = alu_src_q ? imm_q : fwd_b;
  assign storedata_o = fwd_b;

  assign ALUCtrl_o  = alu_ctrl_q;
  assign RegWrite_o = reg_write_q;
  assign MemtoReg_o = mem_to_reg_q;
  assign MemRead_o  = mem_read_q;
  assign MemWrite_o = mem_write_q;
  assign RDaddr_o   = rd_addr_q;
  assign valid_o    = valid_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage sitting directly upstream of the ALU in the 5-stage RISC-V core.
- Captures decoded ID-stage fields on each clock edge.
- Resolves EX/MEM and MEM/WB data forwarding and the ALUSrc immediate select, so the ALU sees final operands.
- Emits the registered 3-bit ALU control code, plus control/data for EX/MEM.

Parameters:
- XLEN, 32, datapath width
- RADDR_W, 5, register address width

Ports:
- clk_i  in  1  core clock, all state updates on rising edge
- rst_i  in  1  asynchronous, active-low reset
- stall_i  in  1  hold all stage registers (from hazard unit)
- flush_i  in  1  replace captured instruction with bubble
- RegWrite_i, MemtoReg_i, MemRead_i, MemWrite_i, ALUSrc_i  in  1 each  ID control bits
- ALUOp_i  in  2  00 I-arith, 01 load/store, 10 R-type
- funct_i  in  10  {funct7, funct3}
- RS1data_i, RS2data_i  in  XLEN  register file read data
- imm_i  in  XLEN  sign-extended immediate
- RS1addr_i, RS2addr_i, RDaddr_i  in  RADDR_W  register addresses
- EXMEM_RegWrite_i  in  1  EX/MEM writes a register
- EXMEM_RDaddr_i  in  RADDR_W  EX/MEM destination
- EXMEM_ALUres_i  in  XLEN  EX/MEM ALU result
- MEMWB_RegWrite_i  in  1  MEM/WB writes a register
- MEMWB_RDaddr_i  in  RADDR_W  MEM/WB destination
- MEMWB_WBdata_i  in  XLEN  MEM/WB write-back data
- data1_o, data2_o  out  XLEN  ALU operands
- ALUCtrl_o  out  3  ALU operation code
- storedata_o  out  XLEN  forwarded rs2 for stores
- RegWrite_o, MemtoReg_o, MemRead_o, MemWrite_o  out  1 each  registered controls
- RDaddr_o  out  RADDR_W  registered destination (also read by hazard unit)
- valid_o  out  1  stage holds a real instruction

Behaviour:
- Reset (rst_i low, async): all stage registers 0, valid_o=0, all control outputs 0, ALUCtrl_o=000, RDaddr_o=0. Operand outputs follow forwarding logic on zeroed registers (0 when no forward applies).
- Capture priority per edge: flush_i > stall_i > normal load.
  - flush_i=1: control bits, RDaddr, valid cleared; data/address fields may load but must not cause forwarding side effects.
  - stall_i=1 (no flush): every register holds.
  - Otherwise: capture all inputs, valid_o=1.
- ALU control decode, computed from ALUOp_i/funct_i before the register, registered with the stage; latency 1 cycle:
  - ALUOp 10 (R-type): {0000000,111}->000 and; {0000000,100}->001 xor; {0000000,001}->010 sll; {0000000,000}->011 add; {0100000,000}->100 sub; {0000001,000}->101 mul.
  - ALUOp 00 (I-type): funct3 000->110 addi; funct3 101 ->111 srai.
  - ALUOp 01: 110.
  - Any other combination: 011.
- Forwarding, combinational from registered rs addresses, evaluated independently for A (rs1) and B (rs2):
  - If EXMEM_RegWrite_i and EXMEM_RDaddr_i!=0 and equal to rs: use EXMEM_ALUres_i.
  - Else if MEMWB_RegWrite_i and MEMWB_RDaddr_i!=0 and equal: use MEMWB_WBdata_i.
  - Else use registered RSdata.
  - EX/MEM wins when both match.
- Operand select:
  - data1_o = forwarded A.
  - storedata_o = forwarded B.
  - data2_o = registered imm when ALUSrc=1, else forwarded B.
- A bubble (valid_o=0) drives all control outputs 0; data outputs are don't-care.
- Reset asserted mid-stall or mid-flush clears immediately; first post-reset edge behaves as normal capture.

Test Plan:
- Reset low mid-run with valid instruction held -> all controls, ALUCtrl_o, RDaddr_o and valid_o go 0 without a clock edge.
- Capture R-type sub, RS1=10, RS2=3, ALUOp=10, funct={0100000,000}, no forwards -> next cycle ALUCtrl_o=100, data1_o=10, data2_o=3, valid_o=1.
- Capture addi with imm=-4, ALUSrc=1, RS2data=99 -> ALUCtrl_o=110, data2_o=0xFFFFFFFC, storedata_o=99.
- rs1=x5 with EXMEM rd=x5 (res 0x11) and MEMWB rd=x5 (data 0x22), both RegWrite=1 -> data1_o=0x11. Drop EXMEM RegWrite -> 0x22. Set rd=x0 on both -> RS1data.
- stall_i=1 for 3 cycles with changing ID inputs -> outputs frozen. stall_i and flush_i both 1 -> bubble, valid_o=0, RegWrite_o=0, MemWrite_o=0.
- srai decode: ALUOp=00, funct3=101 -> ALUCtrl_o=111. Illegal R funct {0000001,111} -> 011.
